// File: rtl/decode_pkg.sv
// Shared encodings for the decode stage: ALU codes, Ctrl layout,
// FSM states and multi-cycle unit indices.
package decode_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  localparam int CTRL_W         = 19;
  localparam int OFS_REV_SRC    = 0;
  localparam int OFS_REV_B      = 1;
  localparam int OFS_CARRY      = 2;
  localparam int OFS_NO_WRITE   = 3;
  localparam int OFS_FLAG_W     = 4;
  localparam int OFS_ALU        = 6;
  localparam int OFS_REG_SRC    = 9;
  localparam int OFS_IMM_SRC    = 12;
  localparam int OFS_ALU_SRC    = 14;
  localparam int OFS_MEM_TO_REG = 15;
  localparam int OFS_MEM_W      = 16;
  localparam int OFS_REG_W      = 17;
  localparam int OFS_PCS        = 18;

  localparam int MC_MUL = 0;
  localparam int MC_DIV = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] imm_src;
    logic [2:0] reg_src;
    logic [2:0] alu_ctrl;
    logic [1:0] flag_w;
    logic       no_write;
    logic       carry_used;
    logic       rev_b;
    logic       rev_src;
  } ctrl_t;

  // Writeback bundle for a completed multi-cycle result.
  function automatic ctrl_t mc_ctrl();
    ctrl_t c;
    c         = '0;
    c.reg_w   = 1'b1;
    c.reg_src = 3'b100;
    return c;
  endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Combinational instruction decoder: control bundle, multi-cycle
// classification and undefined-encoding detection.
module instr_decode_comb
  import decode_pkg::*;
#(
  parameter int NUM_MC  = 2,
  parameter int MC_OP_W = 1
) (
  input  logic [31:0]        instr_i,
  output ctrl_t              ctrl_o,
  output logic               is_mc_o,
  output logic [MC_OP_W-1:0] mc_idx_o,
  output logic               undef_o
);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic       is_mul;
  logic       is_div;
  logic       is_dp;
  logic       is_mem;
  logic       is_br;
  logic       arith;
  int         unit;
  logic       unused_bits;

  assign op     = instr_i[27:26];
  assign funct  = instr_i[25:20];
  assign cmd    = instr_i[24:21];
  assign rd     = instr_i[15:12];
  assign is_mul = (instr_i[27:21] == 7'd0)
                && (instr_i[7:4] == 4'b1001);
  assign is_div = (op == 2'b01) && (funct == 6'h3F)
                && (instr_i[7:4] == 4'hF);
  assign is_dp  = (op == 2'b00) && !is_mul;
  assign is_mem = (op == 2'b01) && !is_div;
  assign is_br  = (op == 2'b10);

  assign unused_bits = ^{instr_i[31:28], instr_i[19:16],
                         instr_i[11:8], instr_i[3:0]};

  always_comb begin
    ctrl_o  = '0;
    is_mc_o = 1'b0;
    undef_o = 1'b0;
    unit    = 0;
    arith   = 1'b0;
    unique case (1'b1)
      is_mul: begin
        is_mc_o = 1'b1;
        unit    = MC_MUL;
      end
      is_div: begin
        is_mc_o = 1'b1;
        unit    = MC_DIV;
      end
      is_dp: begin
        arith = cmd inside {4'h2, 4'h3, 4'h4, 4'h5,
                            4'h6, 4'h7, 4'hA, 4'hB};
        ctrl_o.alu_src    = funct[5];
        ctrl_o.no_write   = (cmd[3:2] == 2'b10);
        ctrl_o.carry_used = cmd inside {4'h5, 4'h6, 4'h7};
        ctrl_o.rev_src    = (cmd == 4'h3) || (cmd == 4'h7);
        ctrl_o.rev_b      = (cmd[3:1] == 3'b111);
        ctrl_o.flag_w     = funct[0] ? {1'b1, arith} : 2'b00;
        ctrl_o.reg_w      = !ctrl_o.no_write;
        case (cmd)
          4'h0, 4'h8, 4'hE:             ctrl_o.alu_ctrl = ALU_AND;
          4'h1, 4'h9:                   ctrl_o.alu_ctrl = ALU_EOR;
          4'h2, 4'h3, 4'h6, 4'h7, 4'hA: ctrl_o.alu_ctrl = ALU_SUB;
          4'h4, 4'h5, 4'hB:             ctrl_o.alu_ctrl = ALU_ADD;
          4'hC:                         ctrl_o.alu_ctrl = ALU_ORR;
          default:                      ctrl_o.alu_ctrl = ALU_MOV;
        endcase
      end
      is_mem: begin
        ctrl_o.alu_src  = 1'b1;
        ctrl_o.imm_src  = 2'b01;
        ctrl_o.alu_ctrl = instr_i[23] ? ALU_ADD : ALU_SUB;
        if (funct[0]) begin
          ctrl_o.reg_w      = 1'b1;
          ctrl_o.mem_to_reg = 1'b1;
        end else begin
          ctrl_o.mem_w   = 1'b1;
          ctrl_o.reg_src = 3'b010;
        end
      end
      is_br: begin
        ctrl_o.alu_src = 1'b1;
        ctrl_o.imm_src = 2'b10;
        ctrl_o.reg_src = 3'b001;
      end
      default: undef_o = 1'b1;
    endcase
    ctrl_o.pcs = is_br || (ctrl_o.reg_w && (rd == 4'hF));
    // Units beyond the configured count decode as undefined.
    if (is_mc_o && (unit >= NUM_MC)) begin
      is_mc_o = 1'b0;
      undef_o = 1'b1;
    end
  end

  assign mc_idx_o = MC_OP_W'(unit);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: registers decoded control toward execute and
// sequences multi-cycle MUL/DIV operations with a timeout.
module decode_stage
  import decode_pkg::*;
#(
  parameter  int NUM_MC     = 2,
  parameter  int MC_TIMEOUT = 64,
  localparam int MC_OP_W    = (NUM_MC > 1) ? $clog2(NUM_MC) : 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        Instr,
  input  logic               Instr_valid,
  output logic               Instr_ready,
  output logic [18:0]        Ctrl,
  output logic               D_valid,
  input  logic               D_ready,
  output logic               M_Start,
  output logic [MC_OP_W-1:0] MCycleOp,
  input  logic               MC_Done,
  input  logic               Flush,
  output logic               Stall,
  output logic               Undef,
  output logic               MC_Err
);

  localparam int CNT_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MC_TIMEOUT - 1);

  state_e             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic               dvalid_q, dvalid_d;
  logic [MC_OP_W-1:0] mcop_q, mcop_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               undef_q, undef_d;
  logic               mcerr_q, mcerr_d;

  ctrl_t              dec_ctrl;
  logic               dec_mc;
  logic [MC_OP_W-1:0] dec_idx;
  logic               dec_undef;
  logic               accept;

  instr_decode_comb #(
    .NUM_MC  (NUM_MC),
    .MC_OP_W (MC_OP_W)
  ) u_dec (
    .instr_i  (Instr),
    .ctrl_o   (dec_ctrl),
    .is_mc_o  (dec_mc),
    .mc_idx_o (dec_idx),
    .undef_o  (dec_undef)
  );

  // A flush cycle never hands off an instruction.
  assign Instr_ready = !Flush && (state_q == S_IDLE)
                     && (!dvalid_q || D_ready);
  assign accept      = Instr_valid && Instr_ready;

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    dvalid_d = dvalid_q;
    mcop_d   = mcop_q;
    cnt_d    = cnt_q;
    undef_d  = 1'b0;
    mcerr_d  = 1'b0;
    if (Flush) begin
      state_d  = S_IDLE;
      dvalid_d = 1'b0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (dvalid_q && D_ready) dvalid_d = 1'b0;
          if (accept) begin
            if (dec_undef) begin
              undef_d = 1'b1;
            end else if (dec_mc) begin
              state_d = S_ISSUE;
              mcop_d  = dec_idx;
            end else begin
              ctrl_d   = dec_ctrl;
              dvalid_d = 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        S_WAIT: begin
          if (MC_Done) begin
            state_d  = S_DONE;
            ctrl_d   = mc_ctrl();
            dvalid_d = 1'b1;
            cnt_d    = '0;
          end else if (cnt_q == TMO_LAST) begin
            state_d = S_IDLE;
            mcerr_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (D_ready) begin
            state_d  = S_IDLE;
            dvalid_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      dvalid_q <= 1'b0;
      mcop_q   <= '0;
      cnt_q    <= '0;
      undef_q  <= 1'b0;
      mcerr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      dvalid_q <= dvalid_d;
      mcop_q   <= mcop_d;
      cnt_q    <= cnt_d;
      undef_q  <= undef_d;
      mcerr_q  <= mcerr_d;
    end
  end

  assign Ctrl     = ctrl_q;
  assign D_valid  = dvalid_q;
  assign M_Start  = (state_q == S_ISSUE);
  assign MCycleOp = mcop_q;
  assign Stall    = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign Undef    = undef_q;
  assign MC_Err   = mcerr_q;

endmodule
